// File: rtl/ps2_key_encoder.sv
// ps2_key_encoder: PS/2 keyboard receiver and make/break sequence packer.
// Raw pins are synchronised and the clock is glitch-filtered. Frames are
// deserialised and checked, and complete scan-code sequences (including
// E0/F0 prefixes and the 8-byte E1 Pause sequence) are packed into a 65-bit
// event word whose top bit toggles once per completed event.
module ps2_key_encoder #(
    parameter int FILTER_LEN  = 8,
    parameter int TIMEOUT_CYC = 12000
) (
    input  logic        clk_sys,
    input  logic        RESET_N,
    input  logic        ps2_clk_i,
    input  logic        ps2_data_i,
    output logic [64:0] ps2_key,
    output logic        frame_err
);

    localparam int FW = (FILTER_LEN  > 1) ? $clog2(FILTER_LEN)  : 1;
    localparam int TW = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;

    typedef enum logic [1:0] {
        RX_IDLE,
        RX_DATA,
        RX_PARITY,
        RX_STOP
    } rx_state_e;

    // Synchronisers and clock filter
    logic [1:0]    clk_sync_q, clk_sync_d;
    logic [1:0]    data_sync_q, data_sync_d;
    logic          clk_filt_q, clk_filt_d;
    logic [FW-1:0] filt_cnt_q, filt_cnt_d;

    // Receiver
    rx_state_e     state_q, state_d;
    logic [7:0]    shift_q, shift_d;
    logic [2:0]    bit_cnt_q, bit_cnt_d;
    logic          parity_ok_q, parity_ok_d;
    logic          byte_valid_q, byte_valid_d;
    logic          frame_err_q, frame_err_d;
    logic [TW-1:0] tmo_cnt_q, tmo_cnt_d;

    // Sequence packer
    logic [63:0]   acc_q, acc_d;
    logic [2:0]    e1_cnt_q, e1_cnt_d;
    logic [64:0]   key_q, key_d;

    logic          clk_edge;
    logic          clk_fall;
    logic          data_bit;
    logic          clear_seq;
    logic [63:0]   acc_next;
    logic          e1_mode;

    // Input synchronisers and the stable-level clock filter with edge detection
    always_comb begin
        clk_sync_d  = {clk_sync_q[0], ps2_clk_i};
        data_sync_d = {data_sync_q[0], ps2_data_i};
        clk_filt_d  = clk_filt_q;
        filt_cnt_d  = '0;
        if (clk_sync_q[1] != clk_filt_q) begin
            if (filt_cnt_q == FW'(FILTER_LEN - 1)) begin
                clk_filt_d = clk_sync_q[1];
            end else begin
                filt_cnt_d = filt_cnt_q + FW'(1);
            end
        end
        clk_edge = (clk_filt_d != clk_filt_q);
        clk_fall = clk_filt_q & ~clk_filt_d;
        data_bit = data_sync_q[1];
    end

    // Frame receiver next state, including the mid-frame inactivity timeout
    always_comb begin
        state_d      = state_q;
        shift_d      = shift_q;
        bit_cnt_d    = bit_cnt_q;
        parity_ok_d  = parity_ok_q;
        byte_valid_d = 1'b0;
        frame_err_d  = 1'b0;
        clear_seq    = 1'b0;
        tmo_cnt_d    = '0;

        if (clk_fall) begin
            case (state_q)
                RX_IDLE: begin
                    if (!data_bit) begin
                        state_d   = RX_DATA;
                        bit_cnt_d = 3'd0;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
                RX_DATA: begin
                    shift_d = {data_bit, shift_q[7:1]};
                    if (bit_cnt_q == 3'd7) begin
                        state_d = RX_PARITY;
                    end else begin
                        bit_cnt_d = bit_cnt_q + 3'd1;
                    end
                end
                RX_PARITY: begin
                    parity_ok_d = ^{shift_q, data_bit};
                    state_d     = RX_STOP;
                end
                RX_STOP: begin
                    state_d = RX_IDLE;
                    if (data_bit && parity_ok_q) begin
                        byte_valid_d = 1'b1;
                    end else begin
                        frame_err_d = 1'b1;
                        clear_seq   = 1'b1;
                    end
                end
                default: state_d = RX_IDLE;
            endcase
        end

        if (!clk_edge && (state_q != RX_IDLE)) begin
            if (tmo_cnt_q == TW'(TIMEOUT_CYC - 1)) begin
                state_d     = RX_IDLE;
                frame_err_d = 1'b1;
                clear_seq   = 1'b1;
            end else begin
                tmo_cnt_d = tmo_cnt_q + TW'(1);
            end
        end
    end

    // Sequence packer: accumulate prefixes, count E1 sequences, publish events
    always_comb begin
        acc_d    = acc_q;
        e1_cnt_d = e1_cnt_q;
        key_d    = key_q;
        acc_next = {acc_q[55:0], shift_q};
        e1_mode  = ((shift_q == 8'hE1) && (acc_q == 64'd0)) || (e1_cnt_q != 3'd0);

        if (byte_valid_q) begin
            if (e1_mode) begin
                if (e1_cnt_q == 3'd7) begin
                    key_d    = {~key_q[64], acc_next};
                    acc_d    = 64'd0;
                    e1_cnt_d = 3'd0;
                end else begin
                    acc_d    = acc_next;
                    e1_cnt_d = e1_cnt_q + 3'd1;
                end
            end else if ((shift_q == 8'hE0) || (shift_q == 8'hF0)) begin
                acc_d = acc_next;
            end else begin
                key_d = {~key_q[64], acc_next};
                acc_d = 64'd0;
            end
        end

        if (clear_seq) begin
            acc_d    = 64'd0;
            e1_cnt_d = 3'd0;
        end
    end

    // All state registers; reset discards any partial frame and sequence
    always_ff @(posedge clk_sys or negedge RESET_N) begin
        if (!RESET_N) begin
            clk_sync_q   <= 2'b11;
            data_sync_q  <= 2'b11;
            clk_filt_q   <= 1'b1;
            filt_cnt_q   <= '0;
            state_q      <= RX_IDLE;
            shift_q      <= 8'd0;
            bit_cnt_q    <= 3'd0;
            parity_ok_q  <= 1'b0;
            byte_valid_q <= 1'b0;
            frame_err_q  <= 1'b0;
            tmo_cnt_q    <= '0;
            acc_q        <= 64'd0;
            e1_cnt_q     <= 3'd0;
            key_q        <= 65'd0;
        end else begin
            clk_sync_q   <= clk_sync_d;
            data_sync_q  <= data_sync_d;
            clk_filt_q   <= clk_filt_d;
            filt_cnt_q   <= filt_cnt_d;
            state_q      <= state_d;
            shift_q      <= shift_d;
            bit_cnt_q    <= bit_cnt_d;
            parity_ok_q  <= parity_ok_d;
            byte_valid_q <= byte_valid_d;
            frame_err_q  <= frame_err_d;
            tmo_cnt_q    <= tmo_cnt_d;
            acc_q        <= acc_d;
            e1_cnt_q     <= e1_cnt_d;
            key_q        <= key_d;
        end
    end

    assign ps2_key   = key_q;
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_ps2_key_encoder.sv
// tb_ps2_key_encoder: directed and randomized PS/2 frames against a
// queue-based reference model of scan-code sequence packing.
module tb_ps2_key_encoder;

    localparam int TMO = 300;

    logic        clk_sys;
    logic        rst_n;
    logic        ps2_clk;
    logic        ps2_data;
    logic [64:0] ps2_key;
    logic        frame_err;

    int total = 0;
    int bad = 0;
    int err_seen = 0;
    int exp_err = 0;

    logic [64:0] exp_key = 65'd0;
    logic [7:0]  seq_q[$];
    bit          in_e1 = 1'b0;

    ps2_key_encoder #(.FILTER_LEN(8), .TIMEOUT_CYC(TMO)) dut (
        .clk_sys   (clk_sys),
        .RESET_N   (rst_n),
        .ps2_clk_i (ps2_clk),
        .ps2_data_i(ps2_data),
        .ps2_key   (ps2_key),
        .frame_err (frame_err)
    );

    // 10-unit system clock
    initial begin
        clk_sys = 1'b0;
        forever #5 clk_sys = ~clk_sys;
    end

    // Count every frame_err pulse the DUT emits
    always @(posedge clk_sys) begin
        if (frame_err === 1'b1) err_seen++;
    end

    task automatic wait_cyc(input int n);
        repeat (n) @(negedge clk_sys);
    endtask

    task automatic check(input string tag, input logic [64:0] obs, input logic [64:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic check_output(input string tag);
        check({tag, "_key"}, ps2_key, exp_key);
        check({tag, "_err"}, 65'(err_seen), 65'(exp_err));
    endtask

    // Drive the first nbits of a frame (start, 8 data LSB first, parity, stop)
    task automatic apply_stimulus(input logic [7:0] b, input bit bad_par, input int nbits);
        logic [10:0] f;
        f = {1'b1, (~^b) ^ bad_par, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            ps2_data = f[i];
            wait_cyc(10);
            ps2_clk = 1'b0;
            wait_cyc(20);
            ps2_clk = 1'b1;
            wait_cyc(10);
        end
        ps2_data = 1'b1;
    endtask

    // Reference: bytes of the pending sequence, newest last, at most 8 kept
    function automatic logic [63:0] pack_seq();
        logic [63:0] v;
        v = 64'd0;
        foreach (seq_q[i]) v = {v[55:0], seq_q[i]};
        return v;
    endfunction

    task automatic model_byte(input logic [7:0] b);
        bit done;
        if (seq_q.size() == 0 && b == 8'hE1) in_e1 = 1'b1;
        seq_q.push_back(b);
        if (seq_q.size() > 8) void'(seq_q.pop_front());
        if (in_e1) done = (seq_q.size() == 8);
        else       done = !(b == 8'hE0 || b == 8'hF0);
        if (done) begin
            exp_key = {~exp_key[64], pack_seq()};
            seq_q.delete();
            in_e1 = 1'b0;
        end
    endtask

    task automatic model_error();
        exp_err++;
        seq_q.delete();
        in_e1 = 1'b0;
    endtask

    task automatic send_byte(input logic [7:0] b, input string tag);
        apply_stimulus(b, 1'b0, 11);
        model_byte(b);
        wait_cyc(8);
        check_output(tag);
    endtask

    initial begin
        logic [7:0] pause_seq [8];
        logic [7:0] rb;
        int r;

        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};
        rst_n    = 1'b0;
        ps2_clk  = 1'b1;
        ps2_data = 1'b1;
        wait_cyc(5);
        check_output("reset");
        rst_n = 1'b1;
        wait_cyc(5);

        $display("[TB] single make code");
        send_byte(8'h1C, "make_1C");
        check("make_1C_exact", ps2_key, {1'b1, 56'h0, 8'h1C});

        $display("[TB] break then extended make");
        send_byte(8'hF0, "brk_F0");
        send_byte(8'h1C, "brk_1C");
        send_byte(8'hE0, "ext_E0");
        send_byte(8'h75, "ext_75");

        $display("[TB] extended break");
        send_byte(8'hE0, "xb_E0");
        send_byte(8'hF0, "xb_F0");
        send_byte(8'h75, "xb_75");
        check("xb_low24", {41'd0, ps2_key[23:0]}, 65'h0E0F075);

        $display("[TB] pause sequence");
        foreach (pause_seq[i]) send_byte(pause_seq[i], $sformatf("pause%0d", i));
        check("pause_word", {1'b0, ps2_key[63:0]}, {1'b0, 64'hE11477E1F014F077});

        $display("[TB] parity error");
        send_byte(8'hE0, "perr_pre");
        apply_stimulus(8'h1C, 1'b1, 11);
        model_error();
        wait_cyc(8);
        check_output("perr");
        send_byte(8'h32, "perr_next");

        $display("[TB] mid-frame timeout");
        apply_stimulus(8'h29, 1'b0, 5);
        wait_cyc(TMO + 100);
        model_error();
        check_output("tmo");
        send_byte(8'h29, "tmo_next");

        $display("[TB] randomized sequences");
        for (int i = 0; i < 40; i++) begin
            r = $urandom_range(0, 11);
            case (r)
                0, 1:    rb = 8'hE0;
                2, 3:    rb = 8'hF0;
                4:       rb = 8'hE1;
                default: rb = 8'($urandom);
            endcase
            if ($urandom_range(0, 12) == 0) begin
                apply_stimulus(rb, 1'b1, 11);
                model_error();
                wait_cyc(8);
                check_output($sformatf("rnd_perr%0d", i));
            end else begin
                send_byte(rb, $sformatf("rnd%0d", i));
            end
        end

        $display("[TB] reset mid-frame");
        send_byte(8'h5A, "pre_rst");
        apply_stimulus(8'hA5, 1'b0, 4);
        ps2_clk  = 1'b0;
        wait_cyc(2);
        #3;
        rst_n = 1'b0;
        #1;
        check("rst_key", ps2_key, 65'd0);
        check("rst_err", {64'd0, frame_err}, 65'd0);
        ps2_clk = 1'b1;
        exp_key = 65'd0;
        seq_q.delete();
        in_e1 = 1'b0;
        wait_cyc(5);
        rst_n = 1'b1;
        wait_cyc(20);
        send_byte(8'h16, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
